aes_dec_arbiter: RTL and testbench
==================================

Name: aes_dec_arbiter

Overview:
- Shares one iterative AES-128 decryptor engine between NUM_REQ requesters, for example the CPU load/store port and the DMA port.
- Uses round-robin arbitration. Holds one transaction in flight, tracks its owner, and routes the plaintext back to that owner only.
- Sits between the requester-side valid/ready ports and the decryptor's valid/ready/yumi interface. Adds a latency watchdog.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 32, cycles spent in e_wait before err_o asserts. Must be greater than the engine latency of 12.
- TO_W, 6, watchdog counter width. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_data_i  in  NUM_REQ x 128  ciphertext per requester.
- req_v_i  in  NUM_REQ  request valid per requester.
- req_ready_o  out  NUM_REQ  request accepted; one-hot or zero.
- resp_data_o  out  128  plaintext, shared by all requesters.
- resp_v_o  out  NUM_REQ  response valid; one-hot or zero, set only for the owner.
- resp_yumi_i  in  NUM_REQ  response consumed by the owner.
- dec_data_o  out  128  ciphertext to the engine.
- dec_v_o  out  1  engine input valid.
- dec_ready_i  in  1  engine ready.
- dec_data_i  in  128  engine plaintext.
- dec_v_i  in  1  engine output valid.
- dec_yumi_o  out  1  engine output consumed.
- owner_o  out  $clog2(NUM_REQ)  index of the current or last owner.
- err_o  out  1  sticky watchdog error.

Behaviour:
- Reset values:
  - All outputs 0. resp_data_o = 0, owner_o = 0, err_o = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
  - State = e_idle.
  - Reset mid-transaction abandons the transaction with no response. The engine is reset by the same reset_i.
- States: e_idle, e_issue, e_wait, e_return.
- e_idle:
  - grant = first i with req_v_i[i], searching from pointer+1 modulo NUM_REQ.
  - req_ready_o[grant] = 1, combinationally.
  - On a handshake: latch req_data_i[grant] into the data register, owner <= grant, pointer <= grant, go to e_issue.
  - Requesters not granted see req_ready_o = 0 and must hold their requests.
- e_issue:
  - dec_v_o = dec_ready_i. dec_v_o must never be high while dec_ready_i is low, because the engine advances its internal counter on a raw valid.
  - dec_data_o = latched data.
  - When dec_ready_i is high: clear the watchdog, go to e_wait.
- e_wait:
  - Watchdog increments each cycle and saturates. Reaching TIMEOUT_CYCLES sets err_o, which stays set until reset. Keep waiting.
  - When dec_v_i is high: dec_yumi_o = 1 that same cycle, resp_data_o <= dec_data_i, go to e_return.
- e_return:
  - resp_v_o[owner] = 1. resp_data_o is held stable.
  - When resp_yumi_i[owner] is high: go to e_idle.
  - resp_yumi_i from non-owners is ignored.
  - No new request is accepted until the next cycle in e_idle, so there is one transaction in flight.
- Latency:
  - Requester accept at cycle t → engine issue at t+1 (if ready).
  - Engine valid at cycle u → resp_v_o at u+1.
  - Minimum idle-to-idle overhead is 3 cycles plus engine latency.
- Simultaneous requests: round-robin gives strict alternation when all requesters are requesting.
- dec_v_i outside e_wait: ignored, dec_yumi_o = 0.
- dec_data_o = 0 outside e_issue.

Decomposition:
- Shared package aes_pkg: state_e enum (e_idle, e_issue, e_wait, e_return) and localparam AES_BLOCK_W = 128.
- One sub-module, rr_arbiter #(NUM_REQ): inputs req, ptr; outputs grant_oh, grant_idx, any. Combinational round-robin pick, reusable elsewhere.
- The pointer register lives in aes_dec_arbiter.

Test Plan:
1. Single request, with a model engine of 12-cycle latency that returns ~data:
   - Stimulus: reset, then req_v_i[0] with data 0x0011...ff.
   - Response: req_ready_o[0] in the same cycle; dec_v_o one cycle later.
   - Response: resp_v_o = 2'b01 with data ~0x0011...ff, one cycle after dec_v_i.
   - Response: back to e_idle after resp_yumi_i[0].
2. Both requesters valid continuously for 4 transactions:
   - Grants in order 0, 1, 0, 1.
   - owner_o matches each grant; responses never cross over between requesters.
3. Engine dec_ready_i held low for 5 cycles in e_issue:
   - dec_v_o stays 0 for those 5 cycles.
   - Exactly one dec_v_o & dec_ready_i cycle afterwards.
4. Owner stalls resp_yumi_i for 10 cycles while requester 1 is valid:
   - resp_data_o is stable throughout; req_ready_o stays 0.
   - Requester 1 is granted in the cycle after the yumi.
   - resp_yumi_i[1] during the stall has no effect.
5. Engine never returns dec_v_i:
   - err_o rises exactly TIMEOUT_CYCLES (32) cycles after entering e_wait, and stays high.
   - Reset clears err_o and all outputs to 0.
6. reset_i asserted in e_wait:
   - Next cycle: state e_idle, all resp_v_o = 0, pointer favours requester 0.
   - A late dec_v_i is not yumi'd.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types for the AES decryptor sharing logic.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    e_idle,
    e_issue,
    e_wait,
    e_return
  } state_e;

endpackage

// File: rtl/aes_dec_arbiter_if.sv
// Requester-side and engine-side handshake bundle of the shared AES decryptor.
interface aes_dec_arbiter_if
  import aes_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);

  logic [NUM_REQ-1:0][AES_BLOCK_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]                  req_v_i;
  logic [NUM_REQ-1:0]                  req_ready_o;
  logic [AES_BLOCK_W-1:0]              resp_data_o;
  logic [NUM_REQ-1:0]                  resp_v_o;
  logic [NUM_REQ-1:0]                  resp_yumi_i;

  logic [AES_BLOCK_W-1:0]              dec_data_o;
  logic                                dec_v_o;
  logic                                dec_ready_i;
  logic [AES_BLOCK_W-1:0]              dec_data_i;
  logic                                dec_v_i;
  logic                                dec_yumi_o;

  // Arbiter side.
  modport slave (
    input  req_data_i, req_v_i, resp_yumi_i, dec_ready_i, dec_data_i, dec_v_i,
    output req_ready_o, resp_data_o, resp_v_o, dec_data_o, dec_v_o, dec_yumi_o
  );

  // Requesters plus engine side.
  modport master (
    output req_data_i, req_v_i, resp_yumi_i, dec_ready_i, dec_data_i, dec_v_i,
    input  req_ready_o, resp_data_o, resp_v_o, dec_data_o, dec_v_o, dec_yumi_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  // Scan farthest-first so the nearest requester after ptr wins last.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      idx = IDX_W'((int'(ptr) + i) % int'(NUM_REQ));
      if (req[idx]) begin
        grant_idx = idx;
        any       = 1'b1;
      end
    end
    grant_oh = any ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/aes_dec_arbiter.sv
// Shares one iterative AES-128 decryptor between NUM_REQ requesters, one
// transaction in flight, round-robin grant, sticky latency watchdog.
module aes_dec_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned  NUM_REQ        = 2,
  parameter int unsigned  TIMEOUT_CYCLES = 32,
  parameter int unsigned  TO_W           = 6,
  localparam int unsigned IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  aes_dec_arbiter_if.slave    bus,
  output logic [IDX_W-1:0]    owner_o,
  output logic                err_o
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, owner_q, grant_idx;
  logic [NUM_REQ-1:0]     grant_oh;
  logic                   grant_any;
  logic [AES_BLOCK_W-1:0] data_q, resp_data_q;
  logic [TO_W-1:0]        wd_q, wd_nxt;
  logic                   err_q;

  logic [NUM_REQ-1:0]     req_ready, resp_v;
  logic [AES_BLOCK_W-1:0] dec_data;
  logic                   dec_v, dec_yumi;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (bus.req_v_i),
    .ptr       (ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= e_idle;
    else         state_q <= state_d;
  end

  // Next state and handshake strobes; the engine valid is gated by its ready
  // because the engine steps its round counter on a raw valid.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    resp_v    = '0;
    dec_data  = '0;
    dec_v     = 1'b0;
    dec_yumi  = 1'b0;
    case (state_q)
      e_idle: begin
        req_ready = grant_oh;
        if (grant_any) state_d = e_issue;
      end
      e_issue: begin
        dec_v    = bus.dec_ready_i;
        dec_data = data_q;
        if (bus.dec_ready_i) state_d = e_wait;
      end
      e_wait: begin
        dec_yumi = bus.dec_v_i;
        if (bus.dec_v_i) state_d = e_return;
      end
      e_return: begin
        resp_v[owner_q] = 1'b1;
        if (bus.resp_yumi_i[owner_q]) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  assign wd_nxt = (wd_q == '1) ? wd_q : wd_q + TO_W'(1);

  // Request latch, ownership, pointer, plaintext capture and watchdog.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == e_idle && grant_any) begin
        data_q  <= bus.req_data_i[grant_idx];
        owner_q <= grant_idx;
        ptr_q   <= grant_idx;
      end
      if (state_q == e_issue && bus.dec_ready_i) wd_q <= '0;
      if (state_q == e_wait) begin
        wd_q <= wd_nxt;
        if (wd_nxt >= TO_W'(TIMEOUT_CYCLES)) err_q <= 1'b1;
        if (bus.dec_v_i) resp_data_q <= bus.dec_data_i;
      end
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.resp_v_o    = resp_v;
  assign bus.resp_data_o = resp_data_q;
  assign bus.dec_data_o  = dec_data;
  assign bus.dec_v_o     = dec_v;
  assign bus.dec_yumi_o  = dec_yumi;
  assign owner_o         = owner_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Directed bench for aes_dec_arbiter with a 12-cycle model engine returning ~data.
module tb_aes_dec_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic owner;
  logic err;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] D0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] D1 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] D2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] D3 = 128'hdeadbeefcafef00d0123456701234567;

  aes_dec_arbiter_if #(.NUM_REQ(2)) bus ();

  aes_dec_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (32),
    .TO_W           (6)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus),
    .owner_o (owner),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  // Model engine: accepts when idle, answers ~data 12 cycles later, holds until yumi.
  logic         eng_busy;
  logic [3:0]   eng_cnt;
  logic [127:0] eng_data;
  logic         eng_hold = 1'b0;
  logic         eng_mute = 1'b0;
  logic         force_v  = 1'b0;

  assign bus.dec_ready_i = !eng_busy && !eng_hold;
  assign bus.dec_v_i     = (eng_busy && eng_cnt == 4'd0 && !eng_mute) || force_v;
  assign bus.dec_data_i  = ~eng_data;

  always @(posedge clk) begin
    if (reset) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 4'd0;
      eng_data <= '0;
    end else if (!eng_busy) begin
      if (bus.dec_v_o && bus.dec_ready_i) begin
        eng_busy <= 1'b1;
        eng_cnt  <= 4'd11;
        eng_data <= bus.dec_data_o;
      end
    end else if (eng_cnt != 4'd0) begin
      eng_cnt <= eng_cnt - 4'd1;
    end else if (bus.dec_yumi_o) begin
      eng_busy <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    bus.req_v_i     = '0;
    bus.resp_yumi_i = '0;
    bus.req_data_i  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_resp(input string tag, input int limit);
    int k = 0;
    while (bus.resp_v_o == '0 && k < limit) begin
      step();
      k++;
    end
    check_eq(tag, 128'(bus.resp_v_o != '0), 128'(1));
  endtask

  // Serve one grant with both requesters held valid; g is the expected winner.
  task automatic serve(input int g, input logic [127:0] nxt);
    logic [127:0] cap;
    int k = 0;
    while (bus.req_ready_o == '0 && k < 50) begin
      step();
      k++;
    end
    check_eq("t2_grant", 128'(bus.req_ready_o), 128'(1) << g);
    cap = (g == 0) ? bus.req_data_i[0] : bus.req_data_i[1];
    step();
    bus.req_data_i[g] = nxt;
    check_eq("t2_owner", 128'(owner), 128'(g));
    wait_resp("t2_resp_seen", 60);
    check_eq("t2_resp_v", 128'(bus.resp_v_o), 128'(1) << g);
    check_eq("t2_resp_data", bus.resp_data_o, ~cap);
    bus.resp_yumi_i[g] = 1'b1;
    @(negedge clk);
    bus.resp_yumi_i = '0;
    #1;
  endtask

  initial begin
    int k;
    int hs;

    // Test 1: reset state and single request.
    reset_dut();
    check_eq("t1_rst_ready", 128'(bus.req_ready_o), 128'(0));
    check_eq("t1_rst_resp_v", 128'(bus.resp_v_o), 128'(0));
    check_eq("t1_rst_resp_data", bus.resp_data_o, 128'(0));
    check_eq("t1_rst_dec_v", 128'(bus.dec_v_o), 128'(0));
    check_eq("t1_rst_dec_data", bus.dec_data_o, 128'(0));
    check_eq("t1_rst_owner", 128'(owner), 128'(0));
    check_eq("t1_rst_err", 128'(err), 128'(0));
    bus.req_data_i[0] = D0;
    bus.req_v_i = 2'b01;
    #1;
    check_eq("t1_ready", 128'(bus.req_ready_o), 128'(2'b01));
    check_eq("t1_no_dec_v_yet", 128'(bus.dec_v_o), 128'(0));
    step();
    bus.req_v_i = '0;
    #1;
    check_eq("t1_dec_v", 128'(bus.dec_v_o), 128'(1));
    check_eq("t1_dec_data", bus.dec_data_o, D0);
    check_eq("t1_ready_off", 128'(bus.req_ready_o), 128'(0));
    k = 0;
    while (!bus.dec_v_i && k < 40) begin
      step();
      k++;
    end
    check_eq("t1_eng_v_seen", 128'(bus.dec_v_i), 128'(1));
    check_eq("t1_yumi", 128'(bus.dec_yumi_o), 128'(1));
    check_eq("t1_resp_not_yet", 128'(bus.resp_v_o), 128'(0));
    step();
    check_eq("t1_resp_v", 128'(bus.resp_v_o), 128'(2'b01));
    check_eq("t1_resp_data", bus.resp_data_o, ~D0);
    check_eq("t1_dec_data_idle", bus.dec_data_o, 128'(0));
    bus.resp_yumi_i = 2'b01;
    step();
    bus.resp_yumi_i = '0;
    bus.req_v_i = 2'b10;
    #1;
    check_eq("t1_back_idle", 128'(bus.req_ready_o), 128'(2'b10));
    check_eq("t1_resp_v_off", 128'(bus.resp_v_o), 128'(0));
    bus.req_v_i = '0;

    // Test 2: both requesters always valid; strict alternation.
    reset_dut();
    bus.req_data_i[0] = D0;
    bus.req_data_i[1] = D1;
    bus.req_v_i = 2'b11;
    #1;
    serve(0, D2);
    serve(1, D3);
    serve(0, D1);
    serve(1, D0);
    bus.req_v_i = '0;

    // Test 3: engine not ready for 5 cycles in e_issue.
    reset_dut();
    eng_hold = 1'b1;
    bus.req_data_i[0] = D2;
    bus.req_v_i = 2'b01;
    step();
    bus.req_v_i = '0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_dec_v_low", 128'(bus.dec_v_o), 128'(0));
      step();
    end
    eng_hold = 1'b0;
    hs = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.dec_v_o && bus.dec_ready_i) hs++;
      step();
    end
    check_eq("t3_one_issue", 128'(hs), 128'(1));
    wait_resp("t3_resp_seen", 40);
    check_eq("t3_resp_data", bus.resp_data_o, ~D2);
    bus.resp_yumi_i = 2'b01;
    step();
    bus.resp_yumi_i = '0;

    // Test 4: owner stalls yumi while requester 1 waits.
    reset_dut();
    bus.req_data_i[0] = D0;
    bus.req_data_i[1] = D1;
    bus.req_v_i = 2'b01;
    step();
    bus.req_v_i = 2'b10;
    wait_resp("t4_resp_seen", 40);
    bus.resp_yumi_i = 2'b10;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("t4_data_stable", bus.resp_data_o, ~D0);
      check_eq("t4_resp_v_hold", 128'(bus.resp_v_o), 128'(2'b01));
      check_eq("t4_no_ready", 128'(bus.req_ready_o), 128'(0));
      step();
    end
    bus.resp_yumi_i = 2'b01;
    #1;
    check_eq("t4_no_ready_yumi", 128'(bus.req_ready_o), 128'(0));
    @(negedge clk);
    bus.resp_yumi_i = '0;
    #1;
    check_eq("t4_grant1", 128'(bus.req_ready_o), 128'(2'b10));
    check_eq("t4_resp_v_off", 128'(bus.resp_v_o), 128'(0));
    step();
    bus.req_v_i = '0;
    check_eq("t4_owner1", 128'(owner), 128'(1));
    wait_resp("t4_resp1_seen", 40);
    check_eq("t4_resp1_v", 128'(bus.resp_v_o), 128'(2'b10));
    check_eq("t4_resp1_data", bus.resp_data_o, ~D1);
    bus.resp_yumi_i = 2'b10;
    step();
    bus.resp_yumi_i = '0;

    // Test 5: engine never answers; watchdog fires after 32 cycles in e_wait.
    reset_dut();
    eng_mute = 1'b1;
    bus.req_data_i[1] = D3;
    bus.req_v_i = 2'b10;
    step();
    bus.req_v_i = '0;
    #1;
    check_eq("t5_issue", 128'(bus.dec_v_o), 128'(1));
    repeat (32) step();
    check_eq("t5_err_before", 128'(err), 128'(0));
    step();
    check_eq("t5_err_rise", 128'(err), 128'(1));
    repeat (5) step();
    check_eq("t5_err_sticky", 128'(err), 128'(1));
    check_eq("t5_owner_pre", 128'(owner), 128'(1));
    reset = 1'b1;
    step();
    eng_mute = 1'b0;
    check_eq("t5_rst_err", 128'(err), 128'(0));
    check_eq("t5_rst_owner", 128'(owner), 128'(0));
    check_eq("t5_rst_resp_v", 128'(bus.resp_v_o), 128'(0));
    check_eq("t5_rst_resp_data", bus.resp_data_o, 128'(0));
    check_eq("t5_rst_dec_v", 128'(bus.dec_v_o), 128'(0));
    check_eq("t5_rst_yumi", 128'(bus.dec_yumi_o), 128'(0));
    check_eq("t5_rst_ready", 128'(bus.req_ready_o), 128'(0));

    // Test 6: reset while in e_wait, then a stray engine valid.
    reset_dut();
    bus.req_data_i[1] = D1;
    bus.req_v_i = 2'b10;
    step();
    bus.req_v_i = '0;
    repeat (3) step();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    force_v = 1'b1;
    bus.req_v_i = 2'b11;
    #1;
    check_eq("t6_no_yumi", 128'(bus.dec_yumi_o), 128'(0));
    check_eq("t6_resp_v", 128'(bus.resp_v_o), 128'(0));
    check_eq("t6_ptr_fav0", 128'(bus.req_ready_o), 128'(2'b01));
    check_eq("t6_owner", 128'(owner), 128'(0));
    force_v = 1'b0;
    bus.req_v_i = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
